// File: rtl/grid_scanner.sv
// Row-multiplexed scanner for an 8x8 cell grid: double-buffers incoming generations and
// refreshes one row at a time with optional blanking between rows.
module grid_scanner #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned BLANK = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        power,
  input  logic [63:0] grid,
  input  logic        grid_valid,
  output logic [7:0]  row_sel,
  output logic [7:0]  col_data,
  output logic        frame_done,
  output logic [6:0]  alive_count,
  output logic        overrun,
  output logic        busy
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StShow = 2'd1;
  localparam logic [1:0] StBlnk = 2'd2;

  localparam logic [7:0] DwellLast = 8'(DWELL - 1);
  localparam logic [7:0] BlankLast = 8'(BLANK - 1);

  logic [1:0]  state_q, state_d;
  logic [63:0] shadow_q, shadow_d;
  logic [63:0] pending_q, pending_d;
  logic        pend_v_q, pend_v_d;
  logic        loaded_q, loaded_d;
  logic [2:0]  row_q, row_d;
  logic [7:0]  dcnt_q, dcnt_d;
  logic [6:0]  alive_q, alive_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  row_sel_q, row_sel_d;
  logic [7:0]  col_data_q, col_data_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;
  logic        adv, wrap;

  function automatic logic [6:0] popcnt(input logic [63:0] v);
    logic [6:0] s;
    s = '0;
    for (int i = 0; i < 64; i++) s = s + {6'd0, v[i]};
    return s;
  endfunction

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    pend_v_d  = pend_v_q;
    loaded_d  = loaded_q;
    row_d     = row_q;
    dcnt_d    = dcnt_q;
    alive_d   = alive_q;
    overrun_d = overrun_q;
    adv       = 1'b0;
    wrap      = 1'b0;

    if (!power) begin
      state_d   = StIdle;
      pending_d = '0;
      pend_v_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (grid_valid) begin
            shadow_d = grid;
            loaded_d = 1'b1;
            alive_d  = popcnt(grid);
            state_d  = StShow;
            row_d    = 3'd0;
            dcnt_d   = 8'd0;
          end else if (loaded_q) begin
            state_d = StShow;
            row_d   = 3'd0;
            dcnt_d  = 8'd0;
          end
        end
        StShow: begin
          if (dcnt_q == DwellLast) begin
            if (BLANK == 0) begin
              adv = 1'b1;
            end else begin
              state_d = StBlnk;
              dcnt_d  = 8'd0;
            end
          end else begin
            dcnt_d = dcnt_q + 8'd1;
          end
        end
        StBlnk: begin
          if (dcnt_q == BlankLast) adv = 1'b1;
          else dcnt_d = dcnt_q + 8'd1;
        end
        default: state_d = StIdle;
      endcase

      if (adv) begin
        state_d = StShow;
        dcnt_d  = 8'd0;
        row_d   = row_q + 3'd1;
        wrap    = (row_q == 3'd7);
      end

      // Shadow only changes on the wrap edge so a frame is never torn.
      if (state_q != StIdle) begin
        if (wrap) begin
          if (grid_valid) begin
            shadow_d = grid;
            alive_d  = popcnt(grid);
            pend_v_d = 1'b0;
            if (pend_v_q) overrun_d = 1'b1;
          end else if (pend_v_q) begin
            shadow_d = pending_q;
            alive_d  = popcnt(pending_q);
            pend_v_d = 1'b0;
          end
        end else if (grid_valid) begin
          pending_d = grid;
          pend_v_d  = 1'b1;
          if (pend_v_q) overrun_d = 1'b1;
        end
      end
    end

    frame_done_d = wrap;
    busy_d       = (state_d != StIdle);
    row_sel_d    = (state_d == StShow) ? (8'd1 << row_d) : 8'd0;
    col_data_d   = (state_d == StShow) ? shadow_d[8*(7-row_d) +: 8] : 8'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_v_q     <= 1'b0;
      loaded_q     <= 1'b0;
      row_q        <= 3'd0;
      dcnt_q       <= 8'd0;
      alive_q      <= 7'd0;
      overrun_q    <= 1'b0;
      row_sel_q    <= 8'd0;
      col_data_q   <= 8'd0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_v_q     <= pend_v_d;
      loaded_q     <= loaded_d;
      row_q        <= row_d;
      dcnt_q       <= dcnt_d;
      alive_q      <= alive_d;
      overrun_q    <= overrun_d;
      row_sel_q    <= row_sel_d;
      col_data_q   <= col_data_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign row_sel     = row_sel_q;
  assign col_data    = col_data_q;
  assign frame_done  = frame_done_q;
  assign alive_count = alive_q;
  assign overrun     = overrun_q;
  assign busy        = busy_q;

endmodule
